// File: rtl/mul_share_pkg.sv
// Shared constants and types for the multiplier-sharing arbiter.
package mul_share_pkg;

    localparam int A_W         = 35;
    localparam int B_W         = 31;
    localparam int P_W         = 65;
    localparam int MUL_LAT_DEF = 4;
    localparam int ID_W        = 3;  // enough for up to 8 requesters

    // One entry of the tag pipeline: which requester owns the product in flight.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mul_share_arbiter_rr.sv
// Round-robin one-hot grant with a registered last-granted pointer.
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    i_req,
    input  logic            i_block,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_grant_idx
);

    localparam int IW = $clog2(N);

    logic [ID_W-1:0] r_last;

    // Search last+1, last+2, ... modulo N and grant the first active request.
    always_comb begin
        int       w_cand;
        logic     w_found;
        logic [IW-1:0] w_ci;
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = 0;
        w_ci        = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = int'(r_last) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            w_ci = IW'(w_cand);
            if (!w_found && !i_block && i_req[w_ci]) begin
                w_found       = 1'b1;
                o_grant[w_ci] = 1'b1;
                o_grant_idx   = ID_W'(w_cand);
            end
        end
    end

    // Pointer follows the granted index on a handshake; reset favours requester 0.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
        if (rst) begin
            r_last <= ID_W'(N - 1);
        end else if (|o_grant) begin
            r_last <= o_grant_idx;
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Time-shares one pipelined signed multiplier between N_REQ requesters:
// arbitration, operand issue, tag tracking of products, and flush sequencing.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*A_W-1:0]          req_a,
    input  logic [N_REQ*B_W-1:0]          req_b,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          flush,
    output logic [A_W-1:0]                mul_a,
    output logic [B_W-1:0]                mul_b,
    output logic                          mul_rst,
    input  logic [P_W-1:0]                mul_p,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [P_W-1:0]                rsp_p,
    output logic [$clog2(MUL_LAT+2)-1:0]  inflight,
    output logic                          idle
);

    localparam int CNT_W = $clog2(MUL_LAT + 2);

    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_gnt_idx;
    logic             w_hs;
    logic             w_block;
    logic             w_exit;
    tag_t             w_tag_out;
    logic [A_W-1:0]   w_sel_a;
    logic [B_W-1:0]   w_sel_b;

    logic [A_W-1:0]   r_mul_a;
    logic [B_W-1:0]   r_mul_b;
    logic             r_mul_rst;
    tag_t             r_tag [0:MUL_LAT];
    logic [CNT_W-1:0] r_inflight;

    // Grants are suppressed during reset, the flush cycle and the multiplier-reset cycle.
    assign w_block = rst | flush | r_mul_rst;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req_valid),
        .i_block     (w_block),
        .o_grant     (w_grant),
        .o_grant_idx (w_gnt_idx)
    );

    assign req_ready = w_grant;
    assign w_hs      = |w_grant;
    assign w_tag_out = r_tag[MUL_LAT];
    assign w_exit    = w_tag_out.valid;

    // One-hot operand mux driven directly by the grant vector.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_a = req_a[k*A_W +: A_W];
                w_sel_b = req_b[k*B_W +: B_W];
            end
        end
    end

    // Operand registers load only on a handshake; otherwise the multiplier sees stale data whose tag is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (w_hs) begin
            r_mul_a <= w_sel_a;
            r_mul_b <= w_sel_b;
        end
    end

    // Multiplier reset: asserted out of reset, then mirrors flush one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_rst <= 1'b1;
        end else begin
            r_mul_rst <= flush;
        end
    end

    // Tag pipeline aligned with the multiplier latency; flush drops every valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the tag array is a handful of flops, not a RAM, so it is reset; stale valid bits would emit bogus responses.
            for (int k = 0; k <= MUL_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_hs, id: w_gnt_idx};
            for (int k = 1; k <= MUL_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            if (flush) begin
                for (int k = 0; k <= MUL_LAT; k++) begin
                    r_tag[k].valid <= 1'b0;
                end
            end
        end
    end

    // Count accepted operations whose product has not yet come back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else if (flush) begin
            r_inflight <= '0;
        end else if (w_hs && !w_exit) begin
            r_inflight <= r_inflight + CNT_W'(1);
        end else if (!w_hs && w_exit) begin
            r_inflight <= r_inflight - CNT_W'(1);
        end
    end

    // Decode the exiting tag into a one-hot response strobe.
    always_comb begin
        rsp_valid = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rsp_valid[k] = w_exit && !r_mul_rst && (w_tag_out.id == ID_W'(k));
        end
    end

    assign rsp_p    = mul_p;
    assign mul_a    = r_mul_a;
    assign mul_b    = r_mul_b;
    assign mul_rst  = r_mul_rst;
    assign inflight = r_inflight;
    assign idle     = (r_inflight == '0) && !(|req_valid);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter with a behavioural 4-stage multiplier.
module tb_mul_share_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [139:0]  req_a;
    logic [123:0]  req_b;
    logic [3:0]    req_ready;
    logic          flush;
    logic [34:0]   mul_a;
    logic [30:0]   mul_b;
    logic          mul_rst;
    logic [64:0]   mul_p;
    logic [3:0]    rsp_valid;
    logic [64:0]   rsp_p;
    logic [2:0]    inflight;
    logic          idle;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0]  gnt;
        logic [64:0] p;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t e;

    mul_share_arbiter #(.N_REQ(4), .MUL_LAT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .flush     (flush),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_rst   (mul_rst),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .inflight  (inflight),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External multiplier: 4 register stages, synchronous reset.
    logic signed [64:0] m0, m1, m2, m3, ea, eb;
    assign ea    = {{30{mul_a[34]}}, mul_a};
    assign eb    = {{34{mul_b[30]}}, mul_b};
    assign mul_p = m3;
    always @(posedge clk) begin
        if (mul_rst) begin
            m0 <= '0; m1 <= '0; m2 <= '0; m3 <= '0;
        end else begin
            m0 <= ea * eb; m1 <= m0; m2 <= m1; m3 <= m2;
        end
    end

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every response strobe must match the head of the scoreboard, including arrival cycle.
    always @(negedge clk) begin
        if (rsp_valid !== 4'b0) begin
            if (q.size() == 0) begin
                check("rsp_unexpected", 65'(rsp_valid), 65'(0));
            end else begin
                e = q.pop_front();
                check("rsp_id", 65'(rsp_valid), 65'(e.gnt));
                check("rsp_p", rsp_p, e.p);
                check("rsp_cycle", 65'(cyc), 65'(e.due));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [34:0] a, input logic [30:0] b);
        req_a[i*35 +: 35] = a;
        req_b[i*31 +: 31] = b;
    endtask

    // Drive one cycle of requests, check the grant, and queue the expected response.
    task automatic step(input logic [3:0] v, input logic [3:0] g, input logic [64:0] p,
                        input bit push, input string name);
        exp_t x;
        req_valid = v;
        @(negedge clk);
        check(name, 65'(req_ready), 65'(g));
        if (push) begin
            x.gnt = g; x.p = p; x.due = cyc + 5;
            q.push_back(x);
        end
        tick();
    endtask

    task automatic drain(input string name);
        int i = 0;
        while ((q.size() != 0 || inflight != 3'd0) && i < 40) begin
            tick();
            i++;
        end
        check({name, "_queue"}, 65'(q.size()), 65'(0));
        check({name, "_inflight"}, 65'(inflight), 65'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [34:0] a_min, a_max;
    logic [30:0] b_min, b_max;

    initial begin
        a_min = {1'b1, 34'b0};
        a_max = {1'b0, {34{1'b1}}};
        b_min = {1'b1, 30'b0};
        b_max = {1'b0, {30{1'b1}}};
        rst = 1'b1;
        flush = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;

        // Reset state
        @(negedge clk);
        check("reset_idle", 65'(idle), 65'(1));
        check("reset_ready", 65'(req_ready), 65'(0));
        check("reset_mul_rst", 65'(mul_rst), 65'(1));
        check("reset_inflight", 65'(inflight), 65'(0));

        // Reset release with requester 0 pending: a=3, b=-5
        set_ops(0, 35'sd3, -31'sd5);
        req_valid = 4'b0001;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("release_mul_rst", 65'(mul_rst), 65'(1));
        check("release_ready", 65'(req_ready), 65'(0));
        tick();
        check("release_mul_rst_low", 65'(mul_rst), 65'(0));
        step(4'b0001, 4'b0001, -65'sd15, 1'b1, "grant_r0");
        req_valid = '0;

        // Extreme operands on requester 3, back to back
        set_ops(3, a_min, b_min);
        step(4'b1000, 4'b1000, 65'h1_0000_0000_0000_0000, 1'b1, "ext_nn");
        set_ops(3, a_min, b_max);
        step(4'b1000, 4'b1000, 65'h1_0000_0004_0000_0000, 1'b1, "ext_np");
        set_ops(3, a_max, b_min);
        step(4'b1000, 4'b1000, 65'h1_0000_0000_4000_0000, 1'b1, "ext_pn");
        set_ops(3, a_max, b_max);
        step(4'b1000, 4'b1000, 65'h0_FFFF_FFFB_C000_0001, 1'b1, "ext_pp");
        req_valid = '0;

        // Full contention: pointer now at 3, so order 0,1,2,3,0,1,2,3
        for (int i = 0; i < 4; i++) set_ops(i, 35'(i + 1), 31'sd2);
        for (int k = 0; k < 8; k++)
            step(4'b1111, 4'(1 << (k % 4)), 65'((k % 4 + 1) * 2), 1'b1, "rr_grant");
        req_valid = '0;
        drain("rr_drain");

        // Flush after three back-to-back handshakes
        set_ops(1, 35'sd11, 31'sd13);
        for (int k = 0; k < 3; k++) step(4'b0010, 4'b0010, '0, 1'b0, "pre_flush_grant");
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready", 65'(req_ready), 65'(0));
        check("flush_inflight_before", 65'(inflight), 65'(3));
        tick();
        flush = 1'b0;
        check("flush_mul_rst", 65'(mul_rst), 65'(1));
        check("flush_inflight_after", 65'(inflight), 65'(0));
        @(negedge clk);
        check("mulrst_ready", 65'(req_ready), 65'(0));
        tick();
        check("flush_mul_rst_once", 65'(mul_rst), 65'(0));
        set_ops(1, 35'sd7, -31'sd9);
        step(4'b0010, 4'b0010, -65'sd63, 1'b1, "post_flush_grant");
        req_valid = '0;
        drain("flush_drain");

        // Asynchronous reset between clock edges with two operations in flight
        set_ops(2, 35'sd5, 31'sd5);
        step(4'b0100, 4'b0100, '0, 1'b0, "pre_rst_grant");
        step(4'b0100, 4'b0100, '0, 1'b0, "pre_rst_grant");
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        check("async_inflight", 65'(inflight), 65'(0));
        check("async_mul_a", 65'(mul_a), 65'(0));
        check("async_mul_b", 65'(mul_b), 65'(0));
        check("async_mul_rst", 65'(mul_rst), 65'(1));
        check("async_idle", 65'(idle), 65'(1));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("async_release_mul_rst", 65'(mul_rst), 65'(1));
        check("async_release_idle", 65'(idle), 65'(1));
        tick();

        // Sparse traffic: one request every 7 cycles, alternating requesters 1 and 3
        set_ops(1, -35'sd4, 31'sd6);
        set_ops(3, 35'sd9, -31'sd3);
        for (int n = 0; n < 4; n++) begin
            if (n % 2 == 0) step(4'b0010, 4'b0010, -65'sd24, 1'b1, "sparse_grant");
            else            step(4'b1000, 4'b1000, -65'sd27, 1'b1, "sparse_grant");
            req_valid = '0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                check("sparse_inflight", 65'(inflight), (k < 6) ? 65'(1) : 65'(0));
                check("sparse_idle", 65'(idle), (k < 6) ? 65'(0) : 65'(1));
                tick();
            end
        end

        drain("final_drain");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
